// File: rtl/div_seq_if.sv
// EX-stage request/response bundle for the div_seq divide sequencer.
// The flush wire exists only when DIV_SEQ_FLUSH_EN is defined.
interface div_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;
`ifdef DIV_SEQ_FLUSH_EN
  logic        flush;

  modport master (output start, op, rs1, rs2, flush, input busy, done, result);
  modport slave  (input start, op, rs1, rs2, flush, output busy, done, result);
`else
  modport master (output start, op, rs1, rs2, input busy, done, result);
  modport slave  (input start, op, rs1, rs2, output busy, done, result);
`endif
endinterface

// File: rtl/div_seq.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer: restoring division on a shared external ALU.
// Optional DIV_SEQ_FLUSH_EN adds a flush input that aborts an operation in flight.
module div_seq #(
  parameter int         XLEN    = 32,
  parameter logic [3:0] ALU_ADD = 4'd1,
  parameter logic [3:0] ALU_SUB = 4'd2
) (
  input  logic            clk,
  input  logic            nrst,
  div_seq_if.slave        ex,
  output logic [XLEN-1:0] alu_op_a,
  output logic [XLEN-1:0] alu_op_b,
  output logic [3:0]      alu_ctr,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_less
);

  localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, ITER, FIX, DONE} state_t;

  state_t          state_r;
  logic [1:0]      op_r;
  logic            sign_a_r;
  logic            sign_b_r;
  logic [XLEN-1:0] rs2_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] dvs_r;
  logic [XLEN-1:0] result_r;
  logic [4:0]      cnt_r;
  logic            busy_r;
  logic            done_r;
  logic [XLEN-1:0] alu_a_r;
  logic [XLEN-1:0] alu_b_r;
  logic [3:0]      alu_ctr_r;

  logic            flush_s;
  logic            take_s;
  logic [XLEN-1:0] trial_s;
  logic [XLEN-1:0] rem_step_s;
  logic [XLEN-1:0] quo_step_s;
  logic [XLEN-1:0] fix_x_s;
  logic            fix_neg_s;

`ifdef DIV_SEQ_FLUSH_EN
  assign flush_s = ex.flush;
`else
  assign flush_s = 1'b0;
`endif

  assign ex.busy   = busy_r;
  assign ex.done   = done_r;
  assign ex.result = result_r;
  assign alu_op_a  = alu_a_r;
  assign alu_op_b  = alu_b_r;
  assign alu_ctr   = alu_ctr_r;

  // One restoring step; rem[31] set means the 33-bit trial always exceeds the divisor.
  always_comb begin
    trial_s    = {rem_r[XLEN-2:0], quo_r[XLEN-1]};
    take_s     = rem_r[XLEN-1] | ~alu_less;
    rem_step_s = take_s ? alu_res : trial_s;
    quo_step_s = {quo_r[XLEN-2:0], take_s};
    fix_x_s    = op_r[1] ? rem_step_s : quo_step_s;
    case (op_r)
      2'b00:   fix_neg_s = sign_a_r ^ sign_b_r;
      2'b10:   fix_neg_s = sign_a_r;
      default: fix_neg_s = 1'b0;
    endcase
  end

  // FSM; ALU drive is registered one cycle ahead so it is valid throughout the state that uses it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r   <= IDLE;
      op_r      <= 2'b00;
      sign_a_r  <= 1'b0;
      sign_b_r  <= 1'b0;
      rs2_r     <= ZERO;
      rem_r     <= ZERO;
      quo_r     <= ZERO;
      dvs_r     <= ZERO;
      result_r  <= ZERO;
      cnt_r     <= 5'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      alu_a_r   <= ZERO;
      alu_b_r   <= ZERO;
      alu_ctr_r <= 4'd0;
    end else begin
      alu_a_r   <= ZERO;
      alu_b_r   <= ZERO;
      alu_ctr_r <= 4'd0;
      if (flush_s && (state_r != IDLE)) begin
        state_r <= IDLE;
        busy_r  <= 1'b0;
        done_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            done_r <= 1'b0;
            if (ex.start && !flush_s) begin
              op_r     <= ex.op;
              sign_a_r <= ex.rs1[XLEN-1];
              sign_b_r <= ex.rs2[XLEN-1];
              busy_r   <= 1'b1;
              if (ex.rs2 == ZERO) begin
                result_r <= ex.op[1] ? ex.rs1 : ONES;
                done_r   <= 1'b1;
                state_r  <= DONE;
              end else if (!ex.op[0] && (ex.rs1 == MIN) && (ex.rs2 == ONES)) begin
                result_r <= ex.op[1] ? ZERO : MIN;
                done_r   <= 1'b1;
                state_r  <= DONE;
              end else begin
                rs2_r     <= ex.rs2;
                state_r   <= ABS_A;
                alu_b_r   <= ex.rs1;
                alu_ctr_r <= (!ex.op[0] && ex.rs1[XLEN-1]) ? ALU_SUB : ALU_ADD;
              end
            end else begin
              busy_r <= 1'b0;
            end
          end
          ABS_A: begin
            quo_r     <= alu_res;
            rem_r     <= ZERO;
            state_r   <= ABS_B;
            alu_b_r   <= rs2_r;
            alu_ctr_r <= (!op_r[0] && sign_b_r) ? ALU_SUB : ALU_ADD;
          end
          ABS_B: begin
            dvs_r     <= alu_res;
            cnt_r     <= 5'd31;
            state_r   <= ITER;
            alu_a_r   <= {{(XLEN-1){1'b0}}, quo_r[XLEN-1]};
            alu_b_r   <= alu_res;
            alu_ctr_r <= ALU_SUB;
          end
          ITER: begin
            rem_r <= rem_step_s;
            quo_r <= quo_step_s;
            cnt_r <= cnt_r - 5'd1;
            if (cnt_r == 5'd0) begin
              state_r   <= FIX;
              alu_b_r   <= fix_x_s;
              alu_ctr_r <= fix_neg_s ? ALU_SUB : ALU_ADD;
            end else begin
              alu_a_r   <= {rem_step_s[XLEN-2:0], quo_step_s[XLEN-1]};
              alu_b_r   <= dvs_r;
              alu_ctr_r <= ALU_SUB;
            end
          end
          FIX: begin
            result_r <= alu_res;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end
          DONE: begin
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
          default: begin
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: behavioural ALU, scoreboard queue of expected results.
// Define DIV_SEQ_FLUSH_EN for both RTL and bench to exercise the flush path.
module tb_div_seq;

  localparam logic [3:0] ADD = 4'd1;
  localparam logic [3:0] SUB = 4'd2;

  logic        clk;
  logic        nrst;
  logic [31:0] alu_op_a;
  logic [31:0] alu_op_b;
  logic [3:0]  alu_ctr;
  logic [31:0] alu_res;
  logic        alu_less;

  int          checks;
  int          errors;
  logic [31:0] sb_q[$];

  div_seq_if ex ();

  div_seq dut (
    .clk      (clk),
    .nrst     (nrst),
    .ex       (ex.slave),
    .alu_op_a (alu_op_a),
    .alu_op_b (alu_op_b),
    .alu_ctr  (alu_ctr),
    .alu_res  (alu_res),
    .alu_less (alu_less)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    alu_res = 32'd0;
    if (alu_ctr == ADD) alu_res = alu_op_a + alu_op_b;
    else if (alu_ctr == SUB) alu_res = alu_op_a - alu_op_b;
    else alu_res = 32'd0;
  end
  assign alu_less = (alu_op_a < alu_op_b);

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation, optionally inject a conflicting start at negedge inject_at, wait for done.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int inject_at);
    int   cyc;
    logic busy_ok;
    @(negedge clk);
    ex.start = 1'b1;
    ex.op    = op;
    ex.rs1   = a;
    ex.rs2   = b;
    sb_q.push_back(exp);
    cyc     = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == inject_at) begin
        ex.start = 1'b1;
        ex.op    = 2'b00;
        ex.rs1   = 32'd5;
        ex.rs2   = 32'd0;
      end else begin
        ex.start = 1'b0;
      end
      if (!ex.busy) busy_ok = 1'b0;
    end while (!ex.done && cyc < 100);
    check({tag, " done"}, {31'd0, ex.done}, 32'd1);
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " result"}, ex.result, sb_q.pop_front());
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    int          lat;
    checks   = 0;
    errors   = 0;
    ex.start = 1'b0;
    ex.op    = 2'b00;
    ex.rs1   = 32'd0;
    ex.rs2   = 32'd0;
`ifdef DIV_SEQ_FLUSH_EN
    ex.flush = 1'b0;
`endif
    nrst = 1'b1;
    #1 nrst = 1'b0;
    #2;
    check("reset busy", {31'd0, ex.busy}, 32'd0);
    check("reset done", {31'd0, ex.done}, 32'd0);
    check("reset result", ex.result, 32'd0);
    check("reset alu_op_b", alu_op_b, 32'd0);
    check("reset alu_ctr", {28'd0, alu_ctr}, 32'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 36, 0);
    run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 36, 0);
    run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 36, 0);
    run_op("remu big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 36, 0);
    run_op("div 5/0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("remu x/0", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 1, 0);
    run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run_op("divu overlap", 2'b01, 32'd100, 32'd7, 32'd14, 36, 10);
    run_op("remu after done", 2'b11, 32'd100, 32'd7, 32'd2, 36, 0);
    run_op("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 36, 0);
    run_op("div -8/-3", 2'b00, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 36, 0);

    for (int i = 0; i < 6; i++) begin
      ra  = $urandom;
      rb  = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      rop = 2'($urandom_range(0, 3));
      lat = (rb == 32'd0) ? 1 : 36;
      run_op("random", rop, ra, rb, ref_div(rop, ra, rb), lat, 0);
    end

    // Asynchronous reset in the middle of ITER
    @(negedge clk);
    ex.start = 1'b1;
    ex.op    = 2'b01;
    ex.rs1   = 32'd1000;
    ex.rs2   = 32'd3;
    @(negedge clk);
    ex.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("midreset busy", {31'd0, ex.busy}, 32'd0);
    check("midreset done", {31'd0, ex.done}, 32'd0);
    check("midreset result", ex.result, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    run_op("div after reset", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 36, 0);

`ifdef DIV_SEQ_FLUSH_EN
    begin
      logic saw_done;
      @(negedge clk);
      ex.start = 1'b1;
      ex.op    = 2'b01;
      ex.rs1   = 32'd100;
      ex.rs2   = 32'd7;
      @(negedge clk);
      ex.start = 1'b0;
      repeat (11) @(negedge clk);
      ex.flush = 1'b1;
      @(negedge clk);
      ex.flush = 1'b0;
      check("flush busy", {31'd0, ex.busy}, 32'd0);
      check("flush done", {31'd0, ex.done}, 32'd0);
      check("flush result", ex.result, 32'hFFFF_FFFD);
      saw_done = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (ex.done) saw_done = 1'b1;
      end
      check("flush no done", {31'd0, saw_done}, 32'd0);
      run_op("divu after flush", 2'b01, 32'd100, 32'd7, 32'd14, 36, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
